// File: rtl/abr_pkg.sv
// Shared types for the abr streaming blocks.
// Holds the reader FSM encoding and the skid FIFO capacity.
package abr_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } abr_stream_rd_state_e;

  localparam logic [2:0] ABR_SKID_ENTRIES = 3'd2;

endpackage

// File: rtl/abr_skid_fifo2.sv
// Two-entry FIFO with a registered head; latency push -> head is one cycle.
// Head data is held until popped; push and pop may coincide when full.
module abr_skid_fifo2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_dat,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            count_q;

  assign head_dat = head_q;
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= push_dat;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= push_dat;
          end else if (push) begin
            tail_q  <= push_dat;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          // Full: a push is only honoured alongside a pop, tail shifts to head.
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= push_dat;
            end else begin
              count_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/abr_ram_stream_reader.sv
// Streams len words from an external 1R1W RAM starting at start_addr, wrapping modulo DEPTH.
// First word 3 cycles after start; reads throttle so FIFO plus in-flight words never exceed two.
module abr_ram_stream_reader
  import abr_pkg::*;
#(
  parameter int  DEPTH      = 64,
  parameter int  DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  zeroize_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_re_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);

  abr_stream_rd_state_e  state_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH:0]   popped_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  inflight_q;
  logic                  done_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       final_issue;
  logic       last_word;
  logic [2:0] level;

  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;

  // Words already committed to the FIFO: those stored plus the read whose data lands next cycle.
  assign level = {1'b0, fifo_full, out_valid_o && !fifo_full} + {2'b00, inflight_q};

  assign ram_re_o    = (state_q == RD_RUN) && (issued_q < len_q) && !zeroize_i &&
                       (level < ABR_SKID_ENTRIES + {2'b00, pop});
  assign ram_raddr_o = raddr_q;
  assign final_issue = ram_re_o && (issued_q + CNT_ONE == len_q);
  assign last_word   = (popped_q + CNT_ONE == len_q);
  assign out_last_o  = out_valid_o && last_word;
  assign busy_o      = (state_q != RD_IDLE);
  assign done_o      = done_q;

  abr_skid_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush    (zeroize_i),
    .push     (inflight_q),
    .push_dat (ram_rdata_i),
    .pop      (pop),
    .head_dat (out_data_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RD_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (zeroize_i) begin
      state_q    <= RD_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= ram_re_o;
      done_q     <= 1'b0;
      if (ram_re_o) begin
        issued_q <= issued_q + CNT_ONE;
        raddr_q  <= (raddr_q == ADDR_MAX) ? '0 : raddr_q + 1'b1;
      end
      if (pop) begin
        popped_q <= popped_q + CNT_ONE;
      end
      case (state_q)
        RD_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state_q  <= RD_RUN;
              len_q    <= len_i;
              raddr_q  <= start_addr_i;
              issued_q <= '0;
              popped_q <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RD_RUN: begin
          if (final_issue) begin
            state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (pop && last_word) begin
            state_q <= RD_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abr_ram_stream_reader.sv
// Bench for abr_ram_stream_reader: external RAM model, queue-based reference model and directed scenarios.
module tb_abr_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        zeroize;
  logic        start;
  logic [5:0]  start_addr;
  logic [6:0]  len;
  logic        busy_o;
  logic        done_o;
  logic        ram_re_o;
  logic [5:0]  ram_raddr_o;
  logic [31:0] ram_rdata = 32'h0;
  logic        out_valid_o;
  logic        out_ready;
  logic [31:0] out_data_o;
  logic        out_last_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: expectations for the current cycle and pending words.
  bit          exp_busy = 1'b0;
  bit          exp_done = 1'b0;
  int          exp_addr[$];
  logic [31:0] exp_dat[$];
  bit          exp_last[$];
  int          outst = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] data_prev = 32'h0;
  int          rd_log[$];
  logic [31:0] out_log[$];
  int          done_cnt = 0;

  logic [8:0]  t_re, t_vld, t_last, t_done, t_busy;
  logic [31:0] t_dat [3:6];

  abr_ram_stream_reader #(
    .DEPTH      (64),
    .DATA_WIDTH (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .zeroize_i    (zeroize),
    .start_i      (start),
    .start_addr_i (start_addr),
    .len_i        (len),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ram_re_o     (ram_re_o),
    .ram_raddr_o  (ram_raddr_o),
    .ram_rdata_i  (ram_rdata),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mw(input int a);
    return 32'hA5A5_0000 + 32'(a) * 32'h0001_0101;
  endfunction

  function automatic bit rdy_pat(input int k);
    return (k % 4 == 0) || (k % 4 == 3);
  endfunction

  always @(posedge clk) begin
    if (ram_re_o) ram_rdata <= mw(int'(ram_raddr_o));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    exp_addr.delete();
    exp_dat.delete();
    exp_last.delete();
    outst      = 0;
    stall_prev = 1'b0;
  endtask

  // Per-cycle compare against the model; also computes next-cycle expectations.
  initial begin
    bit nxt_done, nxt_busy, hs;
    int a;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs",
            {25'd0, busy_o, done_o, ram_re_o, out_valid_o, out_last_o, 1'b0, 1'b0} |
            32'(ram_raddr_o) | out_data_o, 32'h0);
        model_clear();
        exp_busy = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (done_o) done_cnt++;
        chk("done", 32'(done_o), 32'(exp_done));
        chk("busy", 32'(busy_o), 32'(exp_busy));
        nxt_done = 1'b0;
        nxt_busy = exp_busy;
        hs = out_valid_o && out_ready;
        if (stall_prev) begin
          chk("hold_valid", 32'(out_valid_o), 32'd1);
          chk("hold_data", out_data_o, data_prev);
        end
        checks++;
        if (outst + int'(ram_re_o) - int'(hs) > 2) begin
          errors++;
          $display("FAIL occupancy_bound actual=%0d required<=2", outst + int'(ram_re_o) - int'(hs));
        end
        if (ram_re_o) begin
          rd_log.push_back(int'(ram_raddr_o));
          outst++;
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_read actual=%0d required=none", ram_raddr_o);
          end else begin
            chk("raddr", 32'(ram_raddr_o), 32'(exp_addr.pop_front()));
          end
        end
        if (hs) begin
          out_log.push_back(out_data_o);
          outst--;
          if (exp_dat.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word actual=0x%0h required=none", out_data_o);
          end else begin
            chk("data", out_data_o, exp_dat.pop_front());
            chk("last", 32'(out_last_o), 32'(exp_last[0]));
            if (exp_last.pop_front()) begin
              nxt_done = 1'b1;
              nxt_busy = 1'b0;
            end
          end
        end
        stall_prev = out_valid_o && !out_ready;
        data_prev  = out_data_o;
        if (zeroize) begin
          model_clear();
          nxt_done = 1'b0;
          nxt_busy = 1'b0;
        end else if (start && !exp_busy) begin
          if (len == 7'd0) begin
            nxt_done = 1'b1;
          end else begin
            nxt_busy = 1'b1;
            for (int i = 0; i < int'(len); i++) begin
              a = (int'(start_addr) + i) % 64;
              exp_addr.push_back(a);
              exp_dat.push_back(mw(a));
              exp_last.push_back(i == int'(len) - 1);
            end
          end
        end
        exp_done = nxt_done;
        exp_busy = nxt_busy;
      end
    end
  end

  task automatic run_xfer(input int a, input int l, input bit toggle);
    rd_log.delete();
    out_log.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 6'(a);
    len        = 7'(l);
    out_ready  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (!exp_busy && !exp_done) return;
      out_ready = toggle ? rdy_pat(k) : 1'b1;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL xfer_timeout actual=busy required=idle within 400 cycles");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; zeroize = 1'b0; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b0;
    t_re   = 9'b0_0001_1110;
    t_vld  = 9'b0_0111_1000;
    t_last = 9'b0_0100_0000;
    t_done = 9'b0_1000_0000;
    t_busy = 9'b0_0111_1110;
    t_dat[3] = 32'hA5AA_0505; t_dat[4] = 32'hA5AB_0606;
    t_dat[5] = 32'hA5AC_0707; t_dat[6] = 32'hA5AD_0808;

    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data", out_data_o, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Cycle-exact run: addr 5, len 4, ready high.
    start = 1'b1; start_addr = 6'd5; len = 7'd4; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("s1_re", 32'(ram_re_o), 32'(t_re[k]));
      if (t_re[k]) chk("s1_raddr", 32'(ram_raddr_o), 32'(4 + k));
      chk("s1_valid", 32'(out_valid_o), 32'(t_vld[k]));
      chk("s1_last", 32'(out_last_o), 32'(t_last[k]));
      chk("s1_done", 32'(done_o), 32'(t_done[k]));
      chk("s1_busy", 32'(busy_o), 32'(t_busy[k]));
      if (t_vld[k]) chk("s1_data", out_data_o, t_dat[k]);
    end

    // Address wrap at the top of the RAM.
    run_xfer(62, 4, 1'b0);
    chk("s2_nreads", 32'(rd_log.size()), 32'd4);
    chk("s2_raddr1", 32'(rd_log[1]), 32'd63);
    chk("s2_raddr2", 32'(rd_log[2]), 32'd0);
    chk("s2_raddr3", 32'(rd_log[3]), 32'd1);
    chk("s2_word0", out_log[0], 32'hA5E3_3E3E);
    chk("s2_word2", out_log[2], 32'hA5A5_0000);
    chk("s2_word3", out_log[3], 32'hA5A6_0101);

    // Toggling backpressure.
    run_xfer(10, 6, 1'b1);
    chk("s3_nwords", 32'(out_log.size()), 32'd6);
    chk("s3_word5", out_log[5], 32'hA5B4_0F0F);

    // Zero-length request.
    run_xfer(7, 0, 1'b0);
    chk("s4_nreads", 32'(rd_log.size()), 32'd0);
    chk("s4_done_cnt", 32'(done_cnt), 32'd1);

    // Full-depth transfer starting near the top.
    run_xfer(60, 64, 1'b0);
    chk("s5_nreads", 32'(rd_log.size()), 32'd64);
    chk("s5_raddr4", 32'(rd_log[4]), 32'd0);
    chk("s5_raddr63", 32'(rd_log[63]), 32'd59);
    chk("s5_done_cnt", 32'(done_cnt), 32'd1);

    // Zeroize during cycle 3 of a len 10 transfer.
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 6'd30; len = 7'd10; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 zeroize = 1'b1;
    @(posedge clk); #1 zeroize = 1'b0;
    @(negedge clk);
    chk("s6_busy", 32'(busy_o), 32'd0);
    chk("s6_valid", 32'(out_valid_o), 32'd0);
    chk("s6_re", 32'(ram_re_o), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("s6_no_done", 32'(done_cnt), 32'd0);
    run_xfer(40, 3, 1'b0);
    chk("s6_restart_n", 32'(out_log.size()), 32'd3);
    chk("s6_restart_w0", out_log[0], 32'hA5CD_2828);

    // Reset asserted while draining with the sink stalled.
    @(posedge clk); #1;
    start = 1'b1; start_addr = 6'd20; len = 7'd2; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("s7_draining", 32'({busy_o, out_valid_o}), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("s7_busy", 32'(busy_o), 32'd0);
    chk("s7_valid", 32'(out_valid_o), 32'd0);
    chk("s7_data", out_data_o, 32'h0);
    chk("s7_raddr", 32'(ram_raddr_o), 32'd0);
    chk("s7_re_last_done", 32'({ram_re_o, out_last_o, done_o}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("s7_no_residue", 32'({out_valid_o, busy_o, done_o}), 32'd0);
    run_xfer(50, 3, 1'b0);
    chk("s7_restart_n", 32'(out_log.size()), 32'd3);
    chk("s7_restart_w2", out_log[2], 32'hA5D9_3434);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abr_ram_stream_reader.md
ABR_RAM_STREAM_READER -- requirements
Module: abr_ram_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 64: word count of the attached 1R1W byte-enable RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: RAM word width.
REQ-003 SHALL derive localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-004 SHALL have port clk_i, input, 1: sole clock; all logic on posedge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port zeroize_i, input, 1: synchronous abort/flush.
REQ-007 SHALL have port start_i, input, 1: launch request, sampled only in IDLE.
REQ-008 SHALL have port start_addr_i, input, ADDR_WIDTH: first word address.
REQ-009 SHALL have port len_i, input, ADDR_WIDTH+1: word count, 0..DEPTH.
REQ-010 SHALL have port busy_o, output, 1: transfer active.
REQ-011 SHALL have port done_o, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port ram_re_o, output, 1: RAM read enable.
REQ-013 SHALL have port ram_raddr_o, output, ADDR_WIDTH: RAM read address.
REQ-014 SHALL have port ram_rdata_i, input, DATA_WIDTH: RAM read data, valid the cycle after ram_re_o.
REQ-015 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, DATA_WIDTH) and out_last_o (output, 1): valid/ready stream.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-017 IDLE SHALL move to RUN on start_i with len_i != 0 and latch start_addr_i and len_i.
REQ-018 IDLE with start_i and len_i == 0 SHALL stay IDLE, issue no reads and pulse done_o in the next cycle.
REQ-019 start_i SHALL be ignored outside IDLE.
REQ-020 RUN SHALL assert ram_re_o when issued < len and (occupancy + inflight - pop) < 2, where pop = out_valid_o && out_ready_i.
REQ-021 Each issue SHALL increment ram_raddr_o modulo DEPTH, wrapping DEPTH-1 -> 0.
REQ-022 SHALL write ram_rdata_i into a 2-entry output FIFO in the cycle after each issue, with no dropped or duplicated words.
REQ-023 out_data_o SHALL be the FIFO head, and out_valid_o SHALL equal FIFO non-empty.
REQ-024 Latency: start_i at cycle 0 -> ram_re_o at cycle 1 -> out_valid_o at cycle 3.
REQ-025 With out_ready_i held high, throughput SHALL be one word per cycle.
REQ-026 out_valid_o SHALL NOT deassert, and out_data_o SHALL stay stable, while out_valid_o && !out_ready_i.
REQ-027 out_last_o SHALL be asserted only with the final word of the transfer.
REQ-028 RUN SHALL move to DRAIN when the final read is issued.
REQ-029 DRAIN SHALL move to IDLE on the handshake of the final word, with done_o pulsing in the following cycle.
REQ-030 busy_o SHALL be high in RUN and DRAIN and low in IDLE.
REQ-031 zeroize_i SHALL, in any state, force IDLE in the next cycle, empty the FIFO, discard in-flight data, clear counters and suppress done_o, taking priority over start_i.
REQ-032 len_i = DEPTH SHALL read every word exactly once, with wrap as in REQ-021.

Reset
REQ-033 rst_i SHALL asynchronously force IDLE, an empty FIFO and zero counters.
REQ-034 Outputs in reset SHALL be: busy_o=0, done_o=0, ram_re_o=0, ram_raddr_o=0, out_valid_o=0, out_last_o=0, out_data_o=0.
REQ-035 Reset asserted mid-transfer SHALL leave no residual output after release.

Structure
REQ-036 SHALL define the FSM state enum in the shared abr package, as abr_stream_rd_state_e.
REQ-037 SHALL implement the 2-entry FIFO as sub-module abr_skid_fifo2 (parameter DATA_WIDTH; push/pop/full/empty).
REQ-038 SHALL use no RAM internally; the RAM is connected externally to ram_* ports.

Verification
REQ-039 Scenario: start_addr=5, len=4, ready=1 -> reads 5,6,7,8 on cycles 1-4; out words on cycles 3-6; last on word 8; done at cycle 7.
REQ-040 Scenario: DEPTH=64, start_addr=62, len=4 -> raddr 62,63,0,1; data order preserved.
REQ-041 Scenario: len=6, ready toggling 1,0,0,1 repeating -> all 6 words in order; data held while stalled; ram_re_o never drives occupancy+inflight past 2.
REQ-042 Scenario: len=0 -> no ram_re_o; done one cycle after start; busy stays 0.
REQ-043 Scenario: zeroize at cycle 3 of len=10 -> IDLE next cycle; FIFO empty; no done; a new start then works normally.
REQ-044 Scenario: rst_i asserted mid-DRAIN -> all outputs 0 immediately (asynchronous); clean restart after release.
